// File: rtl/ps2_key_holder.sv
// PS/2 receiver that tracks the scan code of the key currently held.
// Ports: clock, reset (async low), ps2_clk/ps2_dat in; keyboard_data, byte_valid, frame_error out.
module ps2_key_holder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keyboard_data,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic          clk_s1;
  logic          clk_s2;
  logic          clk_prev;
  logic          dat_s1;
  logic          dat_s2;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          ext;
  logic          brk;

  logic          fall;
  logic          good;
  logic          timeout;
  logic          is_ext;
  logic          is_brk;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Odd parity over data + parity bit, and stop bit must be high.
  assign good    = dat_s2 & (^{shreg, par});
  // A falling edge restarts the idle count, so it wins over a timeout.
  assign timeout = (state != IDLE) && !fall && (to_cnt == TO_MAX);
  assign is_ext  = (shreg == CODE_EXT);
  assign is_brk  = (shreg == CODE_BRK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      par           <= 1'b0;
      to_cnt        <= '0;
      ext           <= 1'b0;
      brk           <= 1'b0;
      keyboard_data <= 8'h00;
      byte_valid    <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else if (!timeout) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (timeout) begin
        state       <= IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
        ext         <= 1'b0;
        brk         <= 1'b0;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
              shreg   <= 8'h00;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!good) begin
              frame_error <= 1'b1;
              ext         <= 1'b0;
              brk         <= 1'b0;
            end else begin
              byte_valid <= 1'b1;
              if (is_ext || is_brk) begin
                ext <= ext | is_ext;
                brk <= brk | is_brk;
              end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (!brk) begin
                  keyboard_data <= shreg;
                end else if (shreg == keyboard_data) begin
                  keyboard_data <= 8'h00;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_holder.sv
// Directed bench for ps2_key_holder.
// Drives PS/2 frames and checks held key, pulses and error handling.
module tb_ps2_key_holder;

  localparam int TO = 200;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] keyboard_data;
  logic       byte_valid;
  logic       frame_error;

  int passed = 0;
  int total = 0;

  int bv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic bv_q = 1'b0;
  logic fe_q = 1'b0;

  ps2_key_holder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .keyboard_data(keyboard_data),
    .byte_valid(byte_valid),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (byte_valid) bv_cnt <= bv_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (byte_valid && frame_error) both_cnt <= both_cnt + 1;
    if ((byte_valid && bv_q) || (frame_error && fe_q)) long_cnt <= long_cnt + 1;
    bv_q <= byte_valid;
    fe_q <= frame_error;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send_bits(input logic [10:0] bits, input int n, output int lat);
    lat = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1 ps2_dat = bits[i];
      repeat (9) @(posedge clock);
      #1 ps2_clk = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clock); #1;
        if (lat < 0 && byte_valid) lat = c;
      end
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad, output int lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    send_bits(bits, 11, lat);
    repeat (20) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    repeat (5) @(posedge clock);
    #1;
    total++; if (keyboard_data !== 8'h00) $display("FAIL reset_kd got %h exp 00", keyboard_data); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL reset_bv got %b exp 0", byte_valid); else passed++;
    total++; if (frame_error !== 1'b0) $display("FAIL reset_fe got %b exp 0", frame_error); else passed++;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
  endtask

  task automatic test_ext_make;
    int b0, f0, lat;
    b0 = bv_cnt; f0 = fe_cnt;
    send_frame(8'hE0, 1'b0, lat);
    total++; if (keyboard_data !== 8'h00) $display("FAIL ext_prefix_kd got %h exp 00", keyboard_data); else passed++;
    send_frame(8'h6B, 1'b0, lat);
    total++; if (lat !== 3) $display("FAIL ext_make_latency got %0d exp 3", lat); else passed++;
    total++; if (keyboard_data !== 8'h6B) $display("FAIL ext_make_kd got %h exp 6b", keyboard_data); else passed++;
    total++; if (bv_cnt - b0 !== 2) $display("FAIL ext_make_bv got %0d exp 2", bv_cnt - b0); else passed++;
    total++; if (fe_cnt - f0 !== 0) $display("FAIL ext_make_fe got %0d exp 0", fe_cnt - f0); else passed++;
  endtask

  task automatic test_ext_break;
    int b0, lat;
    send_frame(8'h74, 1'b0, lat);
    total++; if (keyboard_data !== 8'h74) $display("FAIL make74_kd got %h exp 74", keyboard_data); else passed++;
    b0 = bv_cnt;
    send_frame(8'hE0, 1'b0, lat);
    send_frame(8'hF0, 1'b0, lat);
    total++; if (keyboard_data !== 8'h74) $display("FAIL ext_brk_prefix_kd got %h exp 74", keyboard_data); else passed++;
    send_frame(8'h74, 1'b0, lat);
    total++; if (keyboard_data !== 8'h00) $display("FAIL ext_brk_kd got %h exp 00", keyboard_data); else passed++;
    total++; if (bv_cnt - b0 !== 3) $display("FAIL ext_brk_bv got %0d exp 3", bv_cnt - b0); else passed++;
  endtask

  task automatic test_break_other;
    int lat;
    send_frame(8'h74, 1'b0, lat);
    send_frame(8'hF0, 1'b0, lat);
    send_frame(8'h6B, 1'b0, lat);
    total++; if (keyboard_data !== 8'h74) $display("FAIL brk_other_kd got %h exp 74", keyboard_data); else passed++;
  endtask

  task automatic test_parity_error;
    int b0, f0, lat;
    b0 = bv_cnt; f0 = fe_cnt;
    send_frame(8'h75, 1'b1, lat);
    total++; if (fe_cnt - f0 !== 1) $display("FAIL parity_fe got %0d exp 1", fe_cnt - f0); else passed++;
    total++; if (bv_cnt - b0 !== 0) $display("FAIL parity_bv got %0d exp 0", bv_cnt - b0); else passed++;
    total++; if (keyboard_data !== 8'h74) $display("FAIL parity_kd got %h exp 74", keyboard_data); else passed++;
  endtask

  task automatic test_error_clears_brk;
    int lat;
    send_frame(8'hF0, 1'b0, lat);
    send_frame(8'h75, 1'b1, lat);
    send_frame(8'h6B, 1'b0, lat);
    total++; if (keyboard_data !== 8'h6B) $display("FAIL err_clr_brk_kd got %h exp 6b", keyboard_data); else passed++;
  endtask

  task automatic test_typematic;
    int b0, lat;
    b0 = bv_cnt;
    send_frame(8'h6B, 1'b0, lat);
    send_frame(8'h6B, 1'b0, lat);
    total++; if (keyboard_data !== 8'h6B) $display("FAIL typematic_kd got %h exp 6b", keyboard_data); else passed++;
    total++; if (bv_cnt - b0 !== 2) $display("FAIL typematic_bv got %0d exp 2", bv_cnt - b0); else passed++;
  endtask

  task automatic test_timeout;
    int b0, f0, lat;
    logic [10:0] bits;
    b0 = bv_cnt; f0 = fe_cnt;
    bits = {1'b1, 1'b0, 8'h75, 1'b0};
    send_bits(bits, 5, lat);
    repeat (TO + 20) @(posedge clock);
    #1;
    total++; if (fe_cnt - f0 !== 1) $display("FAIL timeout_fe got %0d exp 1", fe_cnt - f0); else passed++;
    total++; if (bv_cnt - b0 !== 0) $display("FAIL timeout_bv got %0d exp 0", bv_cnt - b0); else passed++;
    total++; if (keyboard_data !== 8'h6B) $display("FAIL timeout_kd got %h exp 6b", keyboard_data); else passed++;
    send_frame(8'h75, 1'b0, lat);
    total++; if (keyboard_data !== 8'h75) $display("FAIL timeout_next_kd got %h exp 75", keyboard_data); else passed++;
    total++; if (fe_cnt - f0 !== 1) $display("FAIL timeout_next_fe got %0d exp 1", fe_cnt - f0); else passed++;
  endtask

  task automatic test_mid_reset;
    int b0, f0, lat;
    logic [10:0] bits;
    b0 = bv_cnt; f0 = fe_cnt;
    bits = {1'b1, 1'b0, 8'h6B, 1'b0};
    send_bits(bits, 6, lat);
    reset = 1'b0;
    #1;
    total++; if (keyboard_data !== 8'h00) $display("FAIL midrst_kd got %h exp 00", keyboard_data); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL midrst_bv got %b exp 0", byte_valid); else passed++;
    total++; if (frame_error !== 1'b0) $display("FAIL midrst_fe got %b exp 0", frame_error); else passed++;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    total++; if (bv_cnt - b0 !== 0) $display("FAIL midrst_nopulse_bv got %0d exp 0", bv_cnt - b0); else passed++;
    total++; if (fe_cnt - f0 !== 0) $display("FAIL midrst_nopulse_fe got %0d exp 0", fe_cnt - f0); else passed++;
    send_frame(8'h6B, 1'b0, lat);
    total++; if (keyboard_data !== 8'h6B) $display("FAIL midrst_next_kd got %h exp 6b", keyboard_data); else passed++;
    total++; if (bv_cnt - b0 !== 1) $display("FAIL midrst_next_bv got %0d exp 1", bv_cnt - b0); else passed++;
  endtask

  task automatic test_pulse_shape;
    total++; if (both_cnt !== 0) $display("FAIL pulse_both got %0d exp 0", both_cnt); else passed++;
    total++; if (long_cnt !== 0) $display("FAIL pulse_width got %0d exp 0", long_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_ext_make;
    test_ext_break;
    test_break_other;
    test_parity_error;
    test_error_clears_brk;
    test_typematic;
    test_timeout;
    test_mid_reset;
    test_pulse_shape;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
